// File: rtl/lfsr_equiv_pkg.sv
// Shared types for the Fibonacci/Galois LFSR equivalence sequencer.
package lfsr_equiv_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam logic [31:0] STIM_POLY_DEF = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_REPORT = 2'd3
  } lfsr_equiv_state_e;

  // Result payload layout, MSB first, at the default counter width.
  typedef struct packed {
    logic                     pass;
    logic                     aborted;
    logic [CNT_WIDTH_DEF-1:0] first_idx;
    logic [CNT_WIDTH_DEF-1:0] mism_cnt;
  } lfsr_equiv_result_t;

endpackage

// File: rtl/lfsr_equiv_seq_if.sv
// Command, LFSR-pair and result signals of the equivalence sequencer.
interface lfsr_equiv_seq_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                     start__ENA;
  logic [CNT_WIDTH-1:0]     start_count;
  logic [31:0]              start_seed;
  logic                     start__RDY;
  logic                     abort__ENA;
  logic                     fib_shiftBit__ENA;
  logic                     gal_shiftBit__ENA;
  logic                     fib_shiftBit_v;
  logic                     gal_shiftBit_v;
  logic                     fib_shiftBit__RDY;
  logic                     gal_shiftBit__RDY;
  logic                     fib_outBit;
  logic                     gal_outBit;
  logic                     fib_outBit__RDY;
  logic                     gal_outBit__RDY;
  logic                     result__ENA;
  logic [2*CNT_WIDTH+1:0]   result_v;
  logic                     result__RDY;

  // Sequencer side.
  modport slave (
    input  start__ENA, start_count, start_seed, abort__ENA,
    input  fib_shiftBit__RDY, gal_shiftBit__RDY,
    input  fib_outBit, gal_outBit, fib_outBit__RDY, gal_outBit__RDY,
    input  result__RDY,
    output start__RDY, fib_shiftBit__ENA, gal_shiftBit__ENA,
    output fib_shiftBit_v, gal_shiftBit_v, result__ENA, result_v
  );

  // Harness side: command source, LFSR pair and result consumer.
  modport master (
    output start__ENA, start_count, start_seed, abort__ENA,
    output fib_shiftBit__RDY, gal_shiftBit__RDY,
    output fib_outBit, gal_outBit, fib_outBit__RDY, gal_outBit__RDY,
    output result__RDY,
    input  start__RDY, fib_shiftBit__ENA, gal_shiftBit__ENA,
    input  fib_shiftBit_v, gal_shiftBit_v, result__ENA, result_v
  );

endinterface

// File: rtl/stim_lfsr32.sv
// 32-bit Galois stimulus generator: loadable seed (zero forced to 1), one step per advance strobe.
module stim_lfsr32
  import lfsr_equiv_pkg::*;
#(
  parameter logic [31:0] POLY = STIM_POLY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  logic        advance_i,
  output logic        bit_o,
  output logic [31:0] state_o
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == 32'h0) ? 32'h1 : seed_i;
    end else if (advance_i) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? POLY : 32'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 32'h0;
    else        state_q <= state_d;
  end

  assign bit_o   = state_q[0];
  assign state_o = state_q;

endmodule

// File: rtl/lfsr_equiv_seq.sv
// Runs a bounded, seeded stimulus stream through a Fib/Gal LFSR pair in lock-step,
// counts output mismatches and reports the verdict on a valid/ready result port.
module lfsr_equiv_seq
  import lfsr_equiv_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter logic [31:0] STIM_POLY = STIM_POLY_DEF
) (
  input logic             CLK,
  input logic             nRST,
  lfsr_equiv_seq_if.slave bus
);

  localparam int unsigned          RES_WIDTH = 2*CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONES  = '1;

  lfsr_equiv_state_e     state_q, state_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]  step_q, step_d;
  logic [CNT_WIDTH-1:0]  mism_cnt_q, mism_cnt_d;
  logic [CNT_WIDTH-1:0]  first_idx_q, first_idx_d;
  logic                  aborted_q, aborted_d;
  logic                  start_rdy_q, start_rdy_d;
  logic                  result_ena_q, result_ena_d;
  logic [RES_WIDTH-1:0]  result_v_q, result_v_d;

  logic                  accept_c;
  logic                  shift_ena_c;
  logic                  pass_c;
  logic                  stim_bit;
  logic [31:0]           stim_state;
  logic                  unused_stim_state;

  // Abort pre-empts a shift that would otherwise issue in the same cycle.
  assign accept_c    = (state_q == ST_IDLE) && bus.start__ENA;
  assign shift_ena_c = (state_q == ST_SHIFT) && bus.fib_shiftBit__RDY &&
                       bus.gal_shiftBit__RDY && !bus.abort__ENA;

  stim_lfsr32 #(
    .POLY (STIM_POLY)
  ) u_stim (
    .clk       (CLK),
    .rst_n     (nRST),
    .load_i    (accept_c),
    .seed_i    (bus.start_seed),
    .advance_i (shift_ena_c),
    .bit_o     (stim_bit),
    .state_o   (stim_state)
  );

  assign unused_stim_state = ^stim_state[31:1];

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    step_d       = step_q;
    mism_cnt_d   = mism_cnt_q;
    first_idx_d  = first_idx_q;
    aborted_d    = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          remaining_d = bus.start_count;
          step_d      = '0;
          mism_cnt_d  = '0;
          first_idx_d = CNT_ONES;
          aborted_d   = 1'b0;
          state_d     = (bus.start_count == '0) ? ST_REPORT : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.abort__ENA) begin
          aborted_d = 1'b1;
          state_d   = ST_REPORT;
        end else if (shift_ena_c) begin
          remaining_d = remaining_q - CNT_WIDTH'(1);
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // An abort here drops the pending compare entirely.
        if (bus.abort__ENA) begin
          aborted_d = 1'b1;
          state_d   = ST_REPORT;
        end else if (bus.fib_outBit__RDY && bus.gal_outBit__RDY) begin
          if (bus.fib_outBit != bus.gal_outBit) begin
            if (mism_cnt_q != CNT_ONES)  mism_cnt_d  = mism_cnt_q + CNT_WIDTH'(1);
            if (first_idx_q == CNT_ONES) first_idx_d = step_q;
          end
          step_d  = step_q + CNT_WIDTH'(1);
          state_d = (remaining_q == '0) ? ST_REPORT : ST_SHIFT;
        end
      end
      ST_REPORT: begin
        if (bus.result__RDY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs follow the next state so they line up with it.
    pass_c       = (mism_cnt_d == '0) && !aborted_d;
    start_rdy_d  = (state_d == ST_IDLE);
    result_ena_d = (state_d == ST_REPORT);
    result_v_d   = (state_d == ST_REPORT) ?
                   {pass_c, aborted_d, first_idx_d, mism_cnt_d} : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      step_q       <= '0;
      mism_cnt_q   <= '0;
      first_idx_q  <= '0;
      aborted_q    <= 1'b0;
      start_rdy_q  <= 1'b1;
      result_ena_q <= 1'b0;
      result_v_q   <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      step_q       <= step_d;
      mism_cnt_q   <= mism_cnt_d;
      first_idx_q  <= first_idx_d;
      aborted_q    <= aborted_d;
      start_rdy_q  <= start_rdy_d;
      result_ena_q <= result_ena_d;
      result_v_q   <= result_v_d;
    end
  end

  assign bus.start__RDY        = start_rdy_q;
  assign bus.fib_shiftBit__ENA = shift_ena_c;
  assign bus.gal_shiftBit__ENA = shift_ena_c;
  assign bus.fib_shiftBit_v    = shift_ena_c & stim_bit;
  assign bus.gal_shiftBit_v    = shift_ena_c & stim_bit;
  assign bus.result__ENA       = result_ena_q;
  assign bus.result_v          = result_v_q;

endmodule

// File: tb/tb_lfsr_equiv_seq.sv
// Self-checking bench for lfsr_equiv_seq: behavioural LFSR pair, stimulus reference and result scoreboard.
module tb_lfsr_equiv_seq;
  import lfsr_equiv_pkg::*;

  localparam int unsigned CW       = 16;
  localparam int unsigned RW       = 2*CW + 2;
  localparam logic [31:0] REF_POLY = 32'h8020_0003;
  localparam logic [7:0]  TAPS     = 8'd45;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  lfsr_equiv_seq_if #(.CNT_WIDTH(CW)) bus ();

  lfsr_equiv_seq #(.CNT_WIDTH(CW), .STIM_POLY(REF_POLY)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Environment state shared by the LFSR-pair model and the tests.
  logic [31:0]  exp_stim;
  logic [7:0]   model;
  logic [127:0] inv_mask;
  int           nshifts, stall_step, stall_cnt;
  int           bit_err, pair_err, stall_err;
  bit           rand_rdy;
  logic         first_bit;

  assign bus.fib_outBit = model[7];
  assign bus.gal_outBit = model[7] ^ ((nshifts > 0 && nshifts <= 128) ? inv_mask[7'(nshifts-1)] : 1'b0);

  // LFSR pair stand-in: drives readiness at negedge, observes shifts just after.
  always begin
    @(negedge CLK);
    if (rand_rdy) begin
      bus.fib_shiftBit__RDY = ($urandom_range(0, 3) != 0);
      bus.gal_shiftBit__RDY = ($urandom_range(0, 3) != 0);
      bus.fib_outBit__RDY   = ($urandom_range(0, 3) != 0);
      bus.gal_outBit__RDY   = ($urandom_range(0, 3) != 0);
    end else begin
      bus.fib_shiftBit__RDY = 1'b1;
      bus.gal_shiftBit__RDY = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      bus.fib_outBit__RDY   = 1'b1;
      bus.gal_outBit__RDY   = 1'b1;
    end
    #1;
    if (nRST === 1'b1) begin
      if (bus.fib_shiftBit__ENA !== bus.gal_shiftBit__ENA || bus.fib_shiftBit_v !== bus.gal_shiftBit_v) pair_err++;
      if (bus.fib_shiftBit__ENA === 1'b1) begin
        if (!bus.fib_shiftBit__RDY || !bus.gal_shiftBit__RDY) stall_err++;
        if (bus.fib_shiftBit_v !== exp_stim[0]) bit_err++;
        if (nshifts == 0) first_bit = bus.fib_shiftBit_v;
        exp_stim = (exp_stim >> 1) ^ (exp_stim[0] ? REF_POLY : 32'h0);
        model    = {model[6:0], bus.fib_shiftBit_v ^ (^(model & TAPS))};
        nshifts++;
        if (nshifts == stall_step) stall_cnt = 4;
      end
    end
  end

  // One complete run; returns latency (cycles after the first post-accept cycle) and the payload.
  task automatic drive_run(input int cnt, input logic [31:0] seed, input int abort_at, input int hold,
                           output int lat, output logic [RW-1:0] res, output int hold_err,
                           output int rdy_err, output bit tmo);
    lat = 0; hold_err = 0; rdy_err = 0; tmo = 1'b0; res = '0;
    @(negedge CLK);
    bus.start__ENA = 1'b1; bus.start_count = 16'(cnt); bus.start_seed = seed; bus.result__RDY = 1'b0;
    exp_stim = (seed == 32'h0) ? 32'h1 : seed; nshifts = 0; model = '0;
    @(negedge CLK);
    bus.start__ENA = 1'b0;
    #1;
    while (bus.result__ENA !== 1'b1) begin
      if (bus.start__RDY !== 1'b0) rdy_err++;
      if (lat >= 4000) begin tmo = 1'b1; bus.abort__ENA = 1'b0; return; end
      @(negedge CLK);
      if (abort_at >= 0 && nshifts == abort_at) begin bus.abort__ENA = 1'b1; abort_at = -1; end
      else bus.abort__ENA = 1'b0;
      #1; lat++;
    end
    bus.abort__ENA = 1'b0;
    if (bus.start__RDY !== 1'b0) rdy_err++;
    res = bus.result_v;
    repeat (hold) begin
      @(negedge CLK); #1;
      if (bus.result__ENA !== 1'b1 || bus.result_v !== res) hold_err++;
      if (bus.start__RDY !== 1'b0) rdy_err++;
    end
    bus.result__RDY = 1'b1;
    @(negedge CLK);
    bus.result__RDY = 1'b0;
    #1;
    if (bus.start__RDY !== 1'b1 || bus.result__ENA !== 1'b0) rdy_err++;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++; if (bus.start__RDY !== 1'b1) $display("FAIL reset_start_rdy: got %b want 1", bus.start__RDY); else n_pass++;
    n_checks++; if ({bus.fib_shiftBit__ENA, bus.gal_shiftBit__ENA} !== 2'b00) $display("FAIL reset_shift_ena: got %b want 00", {bus.fib_shiftBit__ENA, bus.gal_shiftBit__ENA}); else n_pass++;
    n_checks++; if ({bus.fib_shiftBit_v, bus.gal_shiftBit_v} !== 2'b00) $display("FAIL reset_shift_v: got %b want 00", {bus.fib_shiftBit_v, bus.gal_shiftBit_v}); else n_pass++;
    n_checks++; if (bus.result__ENA !== 1'b0 || bus.result_v !== '0) $display("FAIL reset_result: got ena=%b v=%h want 0/0", bus.result__ENA, bus.result_v); else n_pass++;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_count_zero();
    int lat, herr, rerr; logic [RW-1:0] res; bit tmo; lfsr_equiv_result_t r, e;
    inv_mask = '0;
    drive_run(0, 32'd5, -1, 0, lat, res, herr, rerr, tmo);
    r = lfsr_equiv_result_t'(res);
    e = '{pass: 1'b1, aborted: 1'b0, first_idx: 16'hFFFF, mism_cnt: 16'd0};
    n_checks++; if (tmo !== 1'b0) $display("FAIL zero_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (lat !== 0) $display("FAIL zero_latency: got %0d want 0", lat); else n_pass++;
    n_checks++; if (r !== e) $display("FAIL zero_result: got %h want %h", r, e); else n_pass++;
    n_checks++; if (nshifts !== 0) $display("FAIL zero_shifts: got %0d want 0", nshifts); else n_pass++;
    n_checks++; if (rerr !== 0) $display("FAIL zero_start_rdy: got %0d errors want 0", rerr); else n_pass++;
  endtask

  task automatic test_basic();
    int lat, herr, rerr; logic [RW-1:0] res; bit tmo; lfsr_equiv_result_t e;
    inv_mask = '0; bit_err = 0; pair_err = 0;
    drive_run(8, 32'd1, -1, 0, lat, res, herr, rerr, tmo);
    e = '{pass: 1'b1, aborted: 1'b0, first_idx: 16'hFFFF, mism_cnt: 16'd0};
    n_checks++; if (lat !== 16) $display("FAIL basic_latency: got %0d want 16", lat); else n_pass++;
    n_checks++; if (res !== RW'(e)) $display("FAIL basic_result: got %h want %h", res, e); else n_pass++;
    n_checks++; if (nshifts !== 8) $display("FAIL basic_shifts: got %0d want 8", nshifts); else n_pass++;
    n_checks++; if (first_bit !== 1'b1) $display("FAIL basic_first_bit: got %b want 1", first_bit); else n_pass++;
    n_checks++; if (bit_err !== 0) $display("FAIL basic_stim_bits: got %0d wrong bits want 0", bit_err); else n_pass++;
    n_checks++; if (pair_err !== 0) $display("FAIL basic_pair_equal: got %0d diffs want 0", pair_err); else n_pass++;
  endtask

  task automatic test_mismatch();
    int lat, herr, rerr; logic [RW-1:0] res; bit tmo; lfsr_equiv_result_t e;
    inv_mask = '0; inv_mask[3] = 1'b1; inv_mask[7] = 1'b1;
    drive_run(10, $urandom, -1, 0, lat, res, herr, rerr, tmo);
    e = '{pass: 1'b0, aborted: 1'b0, first_idx: 16'd3, mism_cnt: 16'd2};
    n_checks++; if (res !== RW'(e)) $display("FAIL mismatch_result: got %h want %h", res, e); else n_pass++;
    n_checks++; if (lat !== 20) $display("FAIL mismatch_latency: got %0d want 20", lat); else n_pass++;
    inv_mask = '0;
  endtask

  task automatic test_stall();
    int lat, herr, rerr; logic [RW-1:0] res; bit tmo; lfsr_equiv_result_t e;
    stall_err = 0; stall_step = 1;
    drive_run(4, $urandom, -1, 5, lat, res, herr, rerr, tmo);
    stall_step = -1;
    e = '{pass: 1'b1, aborted: 1'b0, first_idx: 16'hFFFF, mism_cnt: 16'd0};
    n_checks++; if (lat !== 11) $display("FAIL stall_latency: got %0d want 11", lat); else n_pass++;
    n_checks++; if (stall_err !== 0) $display("FAIL stall_ena_low: got %0d shifts while stalled want 0", stall_err); else n_pass++;
    n_checks++; if (herr !== 0) $display("FAIL stall_result_hold: got %0d unstable cycles want 0", herr); else n_pass++;
    n_checks++; if (rerr !== 0) $display("FAIL stall_start_rdy: got %0d errors want 0", rerr); else n_pass++;
    n_checks++; if (res !== RW'(e)) $display("FAIL stall_result: got %h want %h", res, e); else n_pass++;
  endtask

  task automatic test_abort();
    int lat, herr, rerr; logic [RW-1:0] res; bit tmo; lfsr_equiv_result_t e;
    // Step 19 is the compare in flight when the abort lands, so its flag must not count.
    inv_mask = '0; inv_mask[5] = 1'b1; inv_mask[19] = 1'b1;
    drive_run(100, $urandom, 20, 0, lat, res, herr, rerr, tmo);
    e = '{pass: 1'b0, aborted: 1'b1, first_idx: 16'd5, mism_cnt: 16'd1};
    n_checks++; if (tmo !== 1'b0) $display("FAIL abort_timeout: got %b want 0", tmo); else n_pass++;
    n_checks++; if (nshifts !== 20) $display("FAIL abort_shifts: got %0d want 20", nshifts); else n_pass++;
    n_checks++; if (res !== RW'(e)) $display("FAIL abort_result: got %h want %h", res, e); else n_pass++;
    inv_mask = '0;
  endtask

  task automatic test_random();
    int lat, herr, rerr, cnt, exp_m, exp_f; logic [RW-1:0] res; bit tmo; logic [31:0] seed;
    lfsr_equiv_result_t e;
    rand_rdy = 1'b1; bit_err = 0; stall_err = 0; pair_err = 0;
    for (int it = 0; it < 6; it++) begin
      cnt  = $urandom_range(1, 40);
      seed = (it == 0) ? 32'h0 : $urandom;
      inv_mask = '0; exp_m = 0; exp_f = 16'hFFFF;
      for (int i = 0; i < cnt; i++) begin
        inv_mask[i] = ($urandom_range(0, 5) == 0);
        if (inv_mask[i]) begin exp_m++; if (exp_f == 16'hFFFF) exp_f = i; end
      end
      drive_run(cnt, seed, -1, $urandom_range(0, 3), lat, res, herr, rerr, tmo);
      e = '{pass: (exp_m == 0), aborted: 1'b0, first_idx: 16'(exp_f), mism_cnt: 16'(exp_m)};
      n_checks++; if (res !== RW'(e)) $display("FAIL rand_result[%0d]: got %h want %h", it, res, e); else n_pass++;
      n_checks++; if (nshifts !== cnt) $display("FAIL rand_shifts[%0d]: got %0d want %0d", it, nshifts, cnt); else n_pass++;
      n_checks++; if ((lat >= 2*cnt) !== 1'b1) $display("FAIL rand_min_latency[%0d]: got %0d want >= %0d", it, lat, 2*cnt); else n_pass++;
    end
    rand_rdy = 1'b0; inv_mask = '0;
    n_checks++; if (bit_err !== 0) $display("FAIL rand_stim_bits: got %0d wrong bits want 0", bit_err); else n_pass++;
    n_checks++; if (stall_err !== 0) $display("FAIL rand_stall: got %0d shifts while not ready want 0", stall_err); else n_pass++;
    n_checks++; if (pair_err !== 0) $display("FAIL rand_pair_equal: got %0d diffs want 0", pair_err); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int lat, herr, rerr, guard; logic [RW-1:0] res; bit tmo; lfsr_equiv_result_t e;
    inv_mask = '0;
    @(negedge CLK);
    bus.start__ENA = 1'b1; bus.start_count = 16'd100; bus.start_seed = 32'h1234_5678;
    exp_stim = 32'h1234_5678; nshifts = 0; model = '0;
    @(negedge CLK);
    bus.start__ENA = 1'b0;
    guard = 0;
    while (nshifts < 5 && guard < 100) begin @(negedge CLK); #2; guard++; end
    n_checks++; if (nshifts !== 5) $display("FAIL midrun_reach_step5: got %0d want 5", nshifts); else n_pass++;
    #2 nRST = 1'b0;
    #1;
    n_checks++; if (bus.start__RDY !== 1'b1) $display("FAIL midrun_start_rdy: got %b want 1", bus.start__RDY); else n_pass++;
    n_checks++; if ({bus.fib_shiftBit__ENA, bus.gal_shiftBit__ENA, bus.fib_shiftBit_v, bus.gal_shiftBit_v} !== 4'b0) $display("FAIL midrun_shift_outputs: got %b want 0000", {bus.fib_shiftBit__ENA, bus.gal_shiftBit__ENA, bus.fib_shiftBit_v, bus.gal_shiftBit_v}); else n_pass++;
    n_checks++; if (bus.result__ENA !== 1'b0 || bus.result_v !== '0) $display("FAIL midrun_result: got ena=%b v=%h want 0/0", bus.result__ENA, bus.result_v); else n_pass++;
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    n_checks++; if (bus.result__ENA !== 1'b0) $display("FAIL midrun_no_result: got %b want 0", bus.result__ENA); else n_pass++;
    drive_run(2, 32'hCAFE_F00D, -1, 1, lat, res, herr, rerr, tmo);
    e = '{pass: 1'b1, aborted: 1'b0, first_idx: 16'hFFFF, mism_cnt: 16'd0};
    n_checks++; if (res !== RW'(e)) $display("FAIL midrun_rerun_result: got %h want %h", res, e); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL midrun_rerun_latency: got %0d want 4", lat); else n_pass++;
    n_checks++; if (nshifts !== 2) $display("FAIL midrun_rerun_shifts: got %0d want 2", nshifts); else n_pass++;
    n_checks++; if (rerr !== 0) $display("FAIL midrun_rerun_handshake: got %0d errors want 0", rerr); else n_pass++;
  endtask

  initial begin
    bus.start__ENA = 1'b0; bus.start_count = '0; bus.start_seed = '0; bus.abort__ENA = 1'b0;
    bus.result__RDY = 1'b0;
    bus.fib_shiftBit__RDY = 1'b1; bus.gal_shiftBit__RDY = 1'b1;
    bus.fib_outBit__RDY = 1'b1; bus.gal_outBit__RDY = 1'b1;
    exp_stim = 32'h1; model = '0; inv_mask = '0; nshifts = 0;
    stall_step = -1; stall_cnt = 0; bit_err = 0; pair_err = 0; stall_err = 0;
    rand_rdy = 1'b0; first_bit = 1'b0;
    test_reset();
    test_count_zero();
    test_basic();
    test_mismatch();
    test_stall();
    test_abort();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1);
  end

endmodule
